// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, then payload MSB first, then idle-gap zeros.
// One bit per clock; a new payload is accepted only while idle.
module seq_frame_tx #(
    parameter int                DATA_W   = 8,
    parameter int                PRE_W    = 4,
    parameter logic [PRE_W-1:0]  PREAMBLE = 4'b1101,
    parameter int                GAP      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int MAX_PD  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_CNT = (MAX_PD > GAP) ? MAX_PD : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int FRAME_W = PRE_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP_S = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Preamble and payload share one shift register; its MSB is always the next bit to send.
    logic [FRAME_W-1:0] frame_sh;

    assign in_ready = (state == IDLE);
    assign busy     = (state == PRE) || (state == DATA) || (state == GAP_S);

    // NOTE: all state and registered outputs update with non-blocking assignments in one
    // clocked block, so every branch reads the pre-edge values consistently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_sh  <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (in_valid) begin
                        state     <= PRE;
                        cnt       <= CNT_W'(PRE_W);
                        frame_sh  <= {PREAMBLE, in_data} << 1;
                        out       <= PREAMBLE[PRE_W-1];
                        out_valid <= 1'b1;
                    end
                end
                PRE: begin
                    out       <= frame_sh[FRAME_W-1];
                    out_valid <= 1'b1;
                    frame_sh  <= frame_sh << 1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= DATA;
                        cnt      <= CNT_W'(DATA_W);
                        out_last <= (DATA_W == 1);
                    end else begin
                        cnt      <= cnt - CNT_W'(1);
                        out_last <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(1)) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (GAP > 0) begin
                            state <= GAP_S;
                            cnt   <= CNT_W'(GAP);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        out       <= frame_sh[FRAME_W-1];
                        out_valid <= 1'b1;
                        out_last  <= (cnt == CNT_W'(2));
                        frame_sh  <= frame_sh << 1;
                        cnt       <= cnt - CNT_W'(1);
                    end
                end
                GAP_S: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default build plus a DATA_W=1, GAP=0 build.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, out, out_valid, out_last, busy;
    logic       in_valid1;
    logic [0:0] in_data1;
    logic       in_ready1, out1, out_valid1, out_last1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_frame_tx dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_last(out_last), .busy(busy)
    );

    seq_frame_tx #(.DATA_W(1), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
        .out_last(out_last1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called right after the accepting edge; checks 13 frame cycles plus the following idle cycle.
    task automatic expect_frame(input logic [7:0] d, input logic keep_valid, input logic [7:0] next_data);
        logic [12:0] bits;
        bits = {4'b1101, d, 1'b0};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = keep_valid;
            if (i == 5) in_data = next_data;
            check($sformatf("%02h out[%0d]", d, i), out, bits[12-i]);
            check($sformatf("%02h valid[%0d]", d, i), out_valid, (i < 12));
            check($sformatf("%02h last[%0d]", d, i), out_last, (i == 11));
            check($sformatf("%02h busy[%0d]", d, i), busy, 1'b1);
        end
        @(negedge clk);
        check($sformatf("%02h ready_after", d), in_ready, 1'b1);
        check($sformatf("%02h valid_after", d), out_valid, 1'b0);
    endtask

    initial begin
        logic [12:0] bits5a;
        logic [4:0]  bits1;
        bits5a = {4'b1101, 8'h5A, 1'b0};
        bits1  = 5'b11011;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (2) @(negedge clk);
        check("rst out", out, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_last", out_last, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst1 in_ready", in_ready1, 1'b1);
        rst = 1'b1;

        // Idle with no offer: nothing moves.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("idle[%0d]", i), {29'd0, out, out_valid, busy}, 32'd0);
        end

        // Single-cycle offer of A5.
        in_valid = 1'b1; in_data = 8'hA5;
        expect_frame(8'hA5, 1'b0, 8'hA5);

        // Payload containing the preamble pattern goes out unmodified.
        in_valid = 1'b1; in_data = 8'hD0;
        expect_frame(8'hD0, 1'b0, 8'hD0);

        // Held offer, data changes mid-frame: back-to-back frames with one idle cycle.
        in_valid = 1'b1; in_data = 8'h3C;
        expect_frame(8'h3C, 1'b1, 8'hFF);
        expect_frame(8'hFF, 1'b0, 8'hFF);

        // Asynchronous reset during payload bit 3.
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            check($sformatf("5A out[%0d]", i), out, bits5a[12-i]);
        end
        check("pre-reset valid", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async out", out, 1'b0);
        check("async out_valid", out_valid, 1'b0);
        check("async busy", busy, 1'b0);
        check("async in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h81;
        expect_frame(8'h81, 1'b0, 8'h81);

        // DATA_W=1, GAP=0 build.
        in_valid1 = 1'b1; in_data1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) in_valid1 = 1'b0;
            check($sformatf("w1 out[%0d]", i), out1, bits1[4-i]);
            check($sformatf("w1 valid[%0d]", i), out_valid1, 1'b1);
            check($sformatf("w1 last[%0d]", i), out_last1, (i == 4));
        end
        @(negedge clk);
        check("w1 ready_after", in_ready1, 1'b1);
        check("w1 busy_after", busy1, 1'b0);
        check("w1 valid_after", out_valid1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
